// File: rtl/aes_pkg.sv
// Shared AES arithmetic: S-box tables, GF(2^8) helpers, inverse round
// transforms and the controller state type. Byte i of a 128-bit state sits at
// [127-8i -: 8]; bytes run down each column first (row = i % 4, col = i / 4).
package aes_pkg;

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} aes_state_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    localparam logic [79:0] RCON_TBL = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[(255 - int'(b)) * 8 +: 8];
    endfunction

    // Round constant for schedule step i (1..10); zero outside that range.
    function automatic logic [7:0] rcon_at(input logic [3:0] i);
        if (i == 4'd0 || i > 4'd10) return 8'h00;
        return RCON_TBL[(10 - int'(i)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        return r;
    endfunction

    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_decrypt_if.sv
// Request/response bundle for the AES-128 decryptor.
interface aes_decrypt_if;
    logic         start_decrypt;
    logic [127:0] data_in;
    logic [127:0] key;
    logic [127:0] out;
    logic         decrypt_done;
    logic         busy;

    modport master (output start_decrypt, data_in, key,
                    input  out, decrypt_done, busy);
    modport slave  (input  start_decrypt, data_in, key,
                    output out, decrypt_done, busy);
endinterface

// File: rtl/aes_key_step.sv
// One forward AES-128 key-schedule step: round key n-1 -> round key n.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk_prev,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = rk_prev;
    assign temp    = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    assign n0      = w0 ^ temp;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign rk_next = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_decrypt_top.sv
// Iterative AES-128 inverse cipher. The key schedule is expanded forward into
// an 11-entry round-key file (one step per clock), then the inverse rounds
// consume it from rk[10] down to rk[0], one round per clock.
module aes_decrypt_top
    import aes_pkg::*;
#(
    parameter int NR      = 10,
    parameter int NK_BITS = 128
) (
    input  logic           clk,
    input  logic           reset,
    aes_decrypt_if.slave   bus
);
    localparam logic [3:0] LAST = 4'(NR);

    aes_state_e         state_q, state_d;
    logic               accept;
    logic [3:0]         cnt;
    logic [NK_BITS-1:0] rk [0:NR];
    logic [NK_BITS-1:0] ct, st, out_q;
    logic               done_q, busy_q;

    logic [3:0]         prev_idx, round_idx;
    logic [NK_BITS-1:0] rk_prev, rk_next, rk_round, inv_core;
    logic [7:0]         rcon_cur;

    // Pick the previous round key for the schedule step and the key for the current inverse round
    always_comb begin
        prev_idx  = cnt - 4'd1;
        round_idx = LAST - cnt;
        rk_prev   = '0;
        rk_round  = '0;
        if (prev_idx <= LAST)  rk_prev  = rk[prev_idx];
        if (round_idx <= LAST) rk_round = rk[round_idx];
    end

    assign rcon_cur = rcon_at(cnt);
    assign inv_core = inv_sub_bytes(inv_shift_rows(st)) ^ rk_round;

    aes_key_step u_key_step (
        .rk_prev (rk_prev),
        .rcon    (rcon_cur),
        .rk_next (rk_next)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; requests are only looked at while idle
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_decrypt) begin
                    accept  = 1'b1;
                    state_d = KEYEXP;
                end
            end
            KEYEXP:  if (cnt == LAST) state_d = ROUND;
            ROUND:   if (cnt == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: capture request, build the schedule, run the inverse rounds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            ct     <= '0;
            st     <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rk[0]  <= bus.key;
                        ct     <= bus.data_in;
                        cnt    <= 4'd1;
                        busy_q <= 1'b1;
                    end
                end
                KEYEXP: begin
                    rk[cnt] <= rk_next;
                    if (cnt == LAST) begin
                        // rk_next is rk[10] here: fold in the initial AddRoundKey
                        st  <= ct ^ rk_next;
                        cnt <= 4'd1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    if (cnt == LAST) begin
                        out_q  <= inv_core;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        cnt    <= 4'd0;
                    end else begin
                        st  <= inv_mix_columns(inv_core);
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out          = out_q;
    assign bus.decrypt_done = done_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_aes_decrypt_top.sv
module tb_aes_decrypt_top;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] sb [256];

    aes_decrypt_if bus();

    aes_decrypt_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_3 = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] CT_3  = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] PT_3  = 128'h54776f204f6e65204e696e652054776f;

    // ---------------- reference model: textbook AES-128 encryption ----------------
    function automatic logic [7:0] gmul_m(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse (a^254) then the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int n = 0; n < 254; n++) inv = gmul_m(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul_m(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++)
                        t[row + 4*c] = s[row + 4*((c + row) % 4)];
                s = t;
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul_m(a0, 8'h02) ^ gmul_m(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul_m(a1, 8'h02) ^ gmul_m(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul_m(a2, 8'h02) ^ gmul_m(a3, 8'h03);
                        s[4*c+3] = gmul_m(a0, 8'h03) ^ a1 ^ a2 ^ gmul_m(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++)
                    s[4*c + j] ^= w[4*r + c][31 - 8*j -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helper (observes only, no checks) ----------------
    task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input bit inject,
                             output logic [127:0] res, output int lat, output int pulses,
                             output logic busy_early, output logic busy_late,
                             output logic [127:0] out_end);
        lat = -1; pulses = 0; res = '0;
        @(negedge clk);
        bus.start_decrypt = 1'b1; bus.data_in = ct; bus.key = k;
        @(posedge clk); #1;
        bus.start_decrypt = 1'b0;
        busy_early = bus.busy;
        bus.data_in = {$urandom, $urandom, $urandom, $urandom};
        bus.key     = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 1; c <= 26; c++) begin
            if (inject && (c == 5 || c == 15)) begin
                bus.start_decrypt = 1'b1;
                bus.data_in = {$urandom, $urandom, $urandom, $urandom};
                bus.key     = {$urandom, $urandom, $urandom, $urandom};
            end
            @(posedge clk); #1;
            bus.start_decrypt = 1'b0;
            if (bus.decrypt_done) begin
                pulses++;
                if (lat < 0) begin lat = c; res = bus.out; end
            end
        end
        busy_late = bus.busy;
        out_end   = bus.out;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (bus.out !== 128'h0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.out); end
        checks++; if (bus.decrypt_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.decrypt_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_fips_b();
        logic [127:0] res, oe; int lat, pulses; logic be, bl;
        run_block(CT_B, KEY_B, 1'b0, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_B) begin errors++; $display("FAIL fipsb_out: got %h want %h", res, PT_B); end
        checks++; if (lat != 20) begin errors++; $display("FAIL fipsb_latency: got %0d want 20", lat); end
        checks++; if (be !== 1'b1) begin errors++; $display("FAIL fipsb_busy_after_accept: got %b want 1", be); end
        checks++; if (oe !== PT_B) begin errors++; $display("FAIL fipsb_out_held: got %h want %h", oe, PT_B); end
    endtask

    task automatic test_fips_c1();
        logic [127:0] res, oe; int lat, pulses; logic be, bl;
        run_block(CT_C, KEY_C, 1'b0, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_C) begin errors++; $display("FAIL fipsc1_out: got %h want %h", res, PT_C); end
        checks++; if (lat != 20) begin errors++; $display("FAIL fipsc1_latency: got %0d want 20", lat); end
    endtask

    task automatic test_single_pulse();
        logic [127:0] res, oe; int lat, pulses; logic be, bl;
        run_block(CT_3, KEY_3, 1'b0, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_3) begin errors++; $display("FAIL case3_out: got %h want %h", res, PT_3); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL case3_done_pulses: got %0d want 1", pulses); end
        checks++; if (bl !== 1'b0) begin errors++; $display("FAIL case3_busy_after: got %b want 0", bl); end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] res, oe; int lat, pulses; logic be, bl;
        run_block(CT_B, KEY_B, 1'b1, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_B) begin errors++; $display("FAIL busy_ignore_out: got %h want %h", res, PT_B); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
        checks++; if (lat != 20) begin errors++; $display("FAIL busy_ignore_latency: got %0d want 20", lat); end
    endtask

    task automatic test_reset_abort();
        logic [127:0] res, oe; int lat, pulses, stray; logic be, bl;
        @(negedge clk);
        bus.start_decrypt = 1'b1; bus.data_in = CT_C; bus.key = KEY_C;
        @(posedge clk); #1;
        bus.start_decrypt = 1'b0;
        repeat (8) @(posedge clk);
        #2; reset = 1'b1; #1;
        checks++; if (bus.out !== 128'h0) begin errors++; $display("FAIL abort_out: got %h want 0", bus.out); end
        checks++; if (bus.decrypt_done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.decrypt_done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        @(negedge clk); reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus.decrypt_done) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", stray); end
        run_block(CT_C, KEY_C, 1'b0, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_C) begin errors++; $display("FAIL abort_recover_out: got %h want %h", res, PT_C); end
        checks++; if (lat != 20) begin errors++; $display("FAIL abort_recover_latency: got %0d want 20", lat); end
    endtask

    task automatic test_loopback();
        logic [127:0] ct, res, oe; int lat, pulses; logic be, bl;
        ct = model_encrypt(PT_B, KEY_B);
        run_block(ct, KEY_B, 1'b0, res, lat, pulses, be, bl, oe);
        checks++; if (res !== PT_B) begin errors++; $display("FAIL loopback_out: got %h want %h", res, PT_B); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt2, ct1, ct2, r1, r2; int d1, d2; logic busy21;
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        ct1 = model_encrypt(PT_B, KEY_B);
        ct2 = model_encrypt(pt2, KEY_B);
        d1 = -1; d2 = -1; busy21 = 1'b0; r1 = '0; r2 = '0;
        @(negedge clk);
        bus.start_decrypt = 1'b1; bus.data_in = ct1; bus.key = KEY_B;
        @(posedge clk); #1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (bus.decrypt_done) begin
                if (d1 < 0) begin d1 = c; r1 = bus.out; bus.data_in = ct2; end
                else if (d2 < 0) begin d2 = c; r2 = bus.out; end
            end
            if (c == 21) begin busy21 = bus.busy; bus.start_decrypt = 1'b0; end
        end
        bus.start_decrypt = 1'b0;
        checks++; if (d1 != 20) begin errors++; $display("FAIL b2b_first_done: got %0d want 20", d1); end
        checks++; if (r1 !== PT_B) begin errors++; $display("FAIL b2b_first_out: got %h want %h", r1, PT_B); end
        checks++; if (busy21 !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: busy got %b want 1", busy21); end
        checks++; if (d2 != 41) begin errors++; $display("FAIL b2b_second_done: got %0d want 41", d2); end
        checks++; if (r2 !== pt2) begin errors++; $display("FAIL b2b_second_out: got %h want %h", r2, pt2); end
    endtask

    task automatic test_random();
        logic [127:0] pt, k, ct, res, oe; int lat, pulses; logic be, bl;
        for (int n = 0; n < 6; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            ct = model_encrypt(pt, k);
            run_block(ct, k, 1'b0, res, lat, pulses, be, bl, oe);
            checks++; if (res !== pt) begin errors++; $display("FAIL random_out[%0d]: got %h want %h", n, res, pt); end
            checks++; if (lat != 20) begin errors++; $display("FAIL random_latency[%0d]: got %0d want 20", n, lat); end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start_decrypt = 1'b0;
        bus.data_in = '0;
        bus.key = '0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_single_pulse();
        test_start_while_busy();
        test_reset_abort();
        test_loopback();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
